axi_mem_slave: RTL
==================

Name: axi_mem_slave

Overview:
- Byte-wide memory slave that terminates the read and write channels of the team's bus master.
- Accepts read addresses and returns bursts of up to 16 data beats.
- Accepts write addresses, absorbs write beats until WLAST, then returns a write response.
- Read and write paths are independent FSMs that share one storage array.

Parameters:
- MEM_DEPTH, 256, number of byte locations; address width is 8 bits, fixed.
- INIT_FILL, 8'h00, value loaded into every location at reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ARVALID  in  1  read address valid
- ARIN  in  16  {ARADDR[15:8], ARLEN[7:4], ARID[3:0]}; beats = ARLEN+1
- ARREADY  out  1  read address accept pulse
- RVALID  out  1  read beat valid
- RREADY  in  1  master accepts read beat
- ROUT  out  9  {RDATA[8:1], RRESP[0]}
- RLAST  out  1  final read beat
- AWVALID  in  1  write address valid
- AWIN  in  12  {AWADDR[11:4], AWID[3:0]}
- AWREADY  out  1  write address accept pulse
- WVALID  in  1  write beat valid
- WDATA  in  8  write byte
- WLAST  in  1  final write beat
- WREADY  out  1  slave accepts write beat
- BVALID  out  1  write response valid
- BREADY  in  1  master accepts response
- BRESP  out  5  {BID[4:1], err[0]}

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - All outputs go to 0.
  - Both FSMs go to IDLE.
  - Beat counters clear.
  - Memory fills with INIT_FILL; the fill is done in parallel with the reset cycle.
- Reset asserted mid-burst abandons the burst; no B response is issued.
- Read FSM, states R_IDLE, R_ADDR, R_DATA:
  - R_IDLE: on ARVALID, latch addr, len and id; go to R_ADDR.
  - R_ADDR: ARREADY=1 for exactly one cycle; go to R_DATA. ARREADY is never high in the same cycle as RVALID.
  - R_DATA: RVALID=1.
    - ROUT[8:1] = mem[(addr+beat) mod 256].
    - ROUT[0] = rresp for the current beat.
    - RLAST = 1 when beat == len.
  - A beat completes on RVALID&&RREADY: beat increments and the next beat appears next cycle.
  - When the last beat completes, go to R_IDLE, RVALID=0, RLAST=0.
  - With RREADY low, ROUT, RVALID and RLAST hold stable.
- Write FSM, states W_IDLE, W_ADDR, W_DATA, W_RESP:
  - W_IDLE: on AWVALID, latch addr and id; go to W_ADDR.
  - W_ADDR: AWREADY=1 for exactly one cycle; go to W_DATA.
  - W_DATA: WREADY=1. On WVALID, write WDATA to mem[(addr+beat) mod 256] at the clock edge, then beat++.
    - If beat reaches 16 without WLAST, further beats are accepted but discarded, and err is set.
    - On WVALID&&WLAST, go to W_RESP; WREADY drops the next cycle.
  - W_RESP: BVALID=1, BRESP={id, err}. Hold until BREADY, then go to W_IDLE and clear err.
- Address arithmetic is 8-bit, wrapping 0xFF to 0x00.
- Simultaneous read of an address being written in the same cycle returns the old data (write-after-read ordering).
- ARVALID or AWVALID arriving while its FSM is busy is ignored; the master must hold valid.

Optional Feature:
- Macro AXI_SLV_WRAP_ERR_EN.
- Defined:
  - A read beat whose address wrapped past 0xFF (addr+beat > 255) returns RRESP=1.
  - A write burst with any wrapped beat sets err in BRESP.
  - Data is still transferred at the wrapped address.
- Undefined: RRESP is always 0, and err reflects only the over-length case.

Decomposition:
- Package axi_mem_pkg holds:
  - read state encodings (R_IDLE=0, R_ADDR=1, R_DATA=2)
  - write state encodings (W_IDLE=0, W_ADDR=1, W_DATA=2, W_RESP=3)
  - field slice constants for ARIN and AWIN
  - MAX_BEATS=16
- One sub-module, axi_mem_array: 256x8 storage with one write port, one combinational read port and reset fill.

Test Plan:
- Single read: preload mem[0x10]=0xA5; ARIN=16'h1003 -> one ARREADY pulse, then one beat ROUT={0xA5,0} with RLAST=1; RVALID low the cycle after handshake.
- Write burst then readback: AWIN=12'h205, 4 beats 0x11..0x44 with WLAST on the 4th -> BVALID with BRESP=5'b0101_0; then ARIN=16'h2031 -> beats 0x11,0x22,0x33,0x44 with RLAST on the 4th.
- Backpressure: read ARLEN=2 with RREADY toggling 1,0,0,1,1 -> ROUT, RVALID and RLAST held during the stall; exactly 3 beats delivered in order.
- Wrap with macro defined: ARIN=16'hFE20 -> beats from addr FE, FF, 00 with RRESP 0,0,1. Without macro -> all RRESP 0.
- Over-length write: 18 beats, WLAST on the 18th -> only 16 locations written; BRESP err=1.
- Mid-burst reset: rst during beat 2 of a 4-beat write -> all outputs 0 next cycle, no BVALID; memory refilled with INIT_FILL.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the byte-wide AXI-style memory slave.
// Read/write FSM encodings, ARIN/AWIN field positions and the burst limit.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_t;

  localparam int AR_ADDR_HI = 15;
  localparam int AR_ADDR_LO = 8;
  localparam int AR_LEN_HI  = 7;
  localparam int AR_LEN_LO  = 4;
  localparam int AR_ID_HI   = 3;
  localparam int AR_ID_LO   = 0;

  localparam int AW_ADDR_HI = 11;
  localparam int AW_ADDR_LO = 4;
  localparam int AW_ID_HI   = 3;
  localparam int AW_ID_LO   = 0;

  localparam int MAX_BEATS  = 16;

  // True when base+beat runs past 0xFF and the 8-bit address has wrapped.
  function automatic logic addr_wraps(input logic [7:0] base, input logic [4:0] beat);
    return ({1'b0, base} + {4'b0000, beat}) > 9'd255;
  endfunction

endpackage

// File: rtl/axi_mem_slave_if.sv
// Read, write and response channel signals between the bus master and the memory slave.
interface axi_mem_slave_if;

  logic        ARVALID;
  logic [15:0] ARIN;
  logic        ARREADY;
  logic        RVALID;
  logic        RREADY;
  logic [8:0]  ROUT;
  logic        RLAST;
  logic        AWVALID;
  logic [11:0] AWIN;
  logic        AWREADY;
  logic        WVALID;
  logic [7:0]  WDATA;
  logic        WLAST;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY;
  logic [4:0]  BRESP;

  modport master (
    output ARVALID, ARIN, RREADY, AWVALID, AWIN, WVALID, WDATA, WLAST, BREADY,
    input  ARREADY, RVALID, ROUT, RLAST, AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  ARVALID, ARIN, RREADY, AWVALID, AWIN, WVALID, WDATA, WLAST, BREADY,
    output ARREADY, RVALID, ROUT, RLAST, AWREADY, WREADY, BVALID, BRESP
  );

endinterface

// File: rtl/axi_mem_array.sv
// Byte storage with one synchronous write port, one combinational read port
// and a whole-array fill to INIT_FILL during the reset cycle.
module axi_mem_array #(
  parameter int         MEM_DEPTH = 256,
  parameter logic [7:0] INIT_FILL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [MEM_DEPTH];

  // Reset fill wins over a write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= INIT_FILL;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_slave.sv
// Memory slave with independent read and write FSMs sharing one byte array.
// Define AXI_SLV_WRAP_ERR_EN to flag beats whose address wrapped past 0xFF.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int         MEM_DEPTH = 256,
  parameter logic [7:0] INIT_FILL = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  axi_mem_slave_if.slave   bus
);

  rd_state_t  r_state, r_next;
  logic [7:0] r_addr;
  logic [3:0] r_len;
  logic [3:0] r_beat;
  logic [3:0] r_id_unused;
  logic [7:0] r_data;
  logic       r_resp;
  logic       r_load;
  logic [3:0] r_load_beat;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_wrap;

  wr_state_t  w_state, w_next;
  logic [7:0] w_addr;
  logic [3:0] w_id;
  logic [4:0] w_beat;
  logic       w_err;
  logic       mem_we;
  logic [7:0] mem_waddr;

  axi_mem_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .INIT_FILL (INIT_FILL)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (bus.WDATA),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // Each beat's data is captured as it is presented so a stalled beat stays put.
  always_comb begin
    r_next      = r_state;
    bus.ARREADY = 1'b0;
    bus.RVALID  = 1'b0;
    bus.RLAST   = 1'b0;
    r_load      = 1'b0;
    r_load_beat = r_beat;
    case (r_state)
      R_IDLE: begin
        if (bus.ARVALID) r_next = R_ADDR;
      end
      R_ADDR: begin
        bus.ARREADY = 1'b1;
        r_next      = R_DATA;
        r_load      = 1'b1;
        r_load_beat = 4'd0;
      end
      R_DATA: begin
        bus.RVALID = 1'b1;
        bus.RLAST  = (r_beat == r_len);
        if (bus.RREADY) begin
          if (r_beat == r_len) begin
            r_next = R_IDLE;
          end else begin
            r_load      = 1'b1;
            r_load_beat = r_beat + 4'd1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign rd_addr = r_addr + {4'b0000, r_load_beat};

`ifdef AXI_SLV_WRAP_ERR_EN
  assign rd_wrap = addr_wraps(r_addr, {1'b0, r_load_beat});
`else
  assign rd_wrap = 1'b0;
`endif

  assign bus.ROUT = (r_state == R_DATA) ? {r_data, r_resp} : 9'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= 8'd0;
      r_len       <= 4'd0;
      r_beat      <= 4'd0;
      r_id_unused <= 4'd0;
      r_data      <= 8'd0;
      r_resp      <= 1'b0;
    end else begin
      if (r_state == R_IDLE && bus.ARVALID) begin
        r_addr      <= bus.ARIN[AR_ADDR_HI:AR_ADDR_LO];
        r_len       <= bus.ARIN[AR_LEN_HI:AR_LEN_LO];
        r_id_unused <= bus.ARIN[AR_ID_HI:AR_ID_LO];
      end
      if (r_load) begin
        r_beat <= r_load_beat;
        r_data <= rd_data;
        r_resp <= rd_wrap;
      end
    end
  end

  // Beats past MAX_BEATS are still handshaken but never reach the array.
  always_comb begin
    w_next      = w_state;
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    mem_we      = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (bus.AWVALID) w_next = W_ADDR;
      end
      W_ADDR: begin
        bus.AWREADY = 1'b1;
        w_next      = W_DATA;
      end
      W_DATA: begin
        bus.WREADY = 1'b1;
        if (bus.WVALID) begin
          mem_we = (w_beat < 5'(MAX_BEATS));
          if (bus.WLAST) w_next = W_RESP;
        end
      end
      W_RESP: begin
        bus.BVALID = 1'b1;
        if (bus.BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign mem_waddr = w_addr + {4'b0000, w_beat[3:0]};
  assign bus.BRESP = (w_state == W_RESP) ? {w_id, w_err} : 5'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr <= 8'd0;
      w_id   <= 4'd0;
      w_beat <= 5'd0;
      w_err  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (bus.AWVALID) begin
            w_addr <= bus.AWIN[AW_ADDR_HI:AW_ADDR_LO];
            w_id   <= bus.AWIN[AW_ID_HI:AW_ID_LO];
            w_beat <= 5'd0;
            w_err  <= 1'b0;
          end
        end
        W_DATA: begin
          if (bus.WVALID) begin
            if (w_beat < 5'(MAX_BEATS)) begin
              w_beat <= w_beat + 5'd1;
`ifdef AXI_SLV_WRAP_ERR_EN
              if (addr_wraps(w_addr, w_beat)) w_err <= 1'b1;
`endif
            end else begin
              w_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (bus.BREADY) w_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
